// File: rtl/edf_fifo_sched.sv
// Earliest-deadline-first scheduler over NUM_Q sync FIFOs: prefetches each FIFO head into a slot and
// presents the held head with the earliest (wrap-safe) deadline. Optional macro: EDF_LATE_DROP_EN.

module edf_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              pop,
  output logic              rd_en,
  output logic              held,
  output logic [DATA_W-1:0] head
);

  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_LAND, S_HOLD} slot_state_e;

  slot_state_e state, state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (!fifo_empty) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LAND;
      S_LAND:  state_nxt = S_HOLD;
      S_HOLD:  if (pop) state_nxt = fifo_empty ? S_EMPTY : S_FETCH;
      default: state_nxt = S_EMPTY;
    endcase
  end

  // rd_en is a flop that is high exactly while the slot sits in S_FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      rd_en <= 1'b0;
      head  <= '0;
    end else begin
      state <= state_nxt;
      rd_en <= (state_nxt == S_FETCH);
      if (state == S_LAND) head <= rd_data;
    end
  end

  assign held = (state == S_HOLD);

endmodule

module edf_fifo_sched #(
  parameter int NUM_Q  = 4,
  parameter int DATA_W = 16,
  parameter int TS_W   = 6,
  parameter int QID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_Q-1:0]        fifo_empty,
  input  logic [NUM_Q*DATA_W-1:0] fifo_rd_data,
  output logic [NUM_Q-1:0]        fifo_rd_en,
  input  logic [TS_W-1:0]         cur_time,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [QID_W-1:0]        out_qid,
  output logic                    late_drop
);

  logic [NUM_Q-1:0]             held, elig, expired, drop_vec, grant_vec, pop;
  logic [NUM_Q-1:0][DATA_W-1:0] head;
  logic [NUM_Q-1:0][TS_W-1:0]   ts;
  logic                         load, win_vld;
  logic [QID_W-1:0]             win;

  // a is earlier than b when the modular difference lands in the upper half.
  function automatic logic earlier(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    logic [TS_W-1:0] d;
    d = a - b;
    return d[TS_W-1];
  endfunction

  for (genvar g = 0; g < NUM_Q; g++) begin : g_slot
    edf_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty[g]),
      .rd_data    (fifo_rd_data[g*DATA_W +: DATA_W]),
      .pop        (pop[g]),
      .rd_en      (fifo_rd_en[g]),
      .held       (held[g]),
      .head       (head[g])
    );
    assign ts[g] = head[g][DATA_W-1 -: TS_W];
  end

`ifdef EDF_LATE_DROP_EN
  always_comb begin
    expired = '0;
    for (int i = 0; i < NUM_Q; i++)
      expired[i] = held[i] && earlier(ts[i], cur_time);
  end
  // Only the lowest expired slot is discarded per cycle.
  assign drop_vec = expired & (~expired + NUM_Q'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) late_drop <= 1'b0;
    else        late_drop <= |drop_vec;
  end
`else
  logic unused_cur_time;
  assign unused_cur_time = ^cur_time;
  assign expired   = '0;
  assign drop_vec  = '0;
  assign late_drop = 1'b0;
`endif

  assign elig = held & ~expired;
  assign load = !out_valid || out_ready;

  // Strictly-earlier replacement keeps the lower index on equal deadlines.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (elig[i] && (!win_vld || earlier(ts[i], ts[win]))) begin
        win_vld = 1'b1;
        win     = QID_W'(i);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (load && win_vld) grant_vec[win] = 1'b1;
  end

  assign pop = grant_vec | drop_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_qid   <= '0;
    end else if (load) begin
      out_valid <= win_vld;
      if (win_vld) begin
        out_data <= head[win];
        out_qid  <= win;
      end
    end
  end

endmodule
